// File: rtl/ex_mem_buf_pkg.sv
// Shared types and defaults for the EX->MEM result buffer.
package ex_mem_buf_pkg;

  // Default widths: result bus and register-index bus
  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;

  // Occupancy of the two-entry buffer
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

  // True when the buffer holds at least one entry
  function automatic logic buf_occupied(input buf_state_e s);
    return (s == BUF_ONE) || (s == BUF_FULL);
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One buffer entry: {wd, wreg, wdata} register with load enable and async clear.
module ex_mem_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] wd_d,
  input  logic              wreg_d,
  input  logic [DATA_W-1:0] wdata_d,
  output logic [ADDR_W-1:0] wd_q,
  output logic              wreg_q,
  output logic [DATA_W-1:0] wdata_q
);

  // Capture the entry when loaded; clear to zero on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else if (load) begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: rtl/ex_mem_buf.sv
// EX->MEM result skid buffer: two entries, valid/ready toward MEM, registered
// ready toward EX, and newest-entry forwarding back to ID.
module ex_mem_buf
  import ex_mem_buf_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq_o,
  output logic              fwd_we_o,
  output logic [ADDR_W-1:0] fwd_wd_o,
  output logic [DATA_W-1:0] fwd_wdata_o
);

  buf_state_e state_reg, state_next;

  logic              push, pop;
  logic              in_wreg;
  logic              h_load, s_load, h_from_s;
  logic [ADDR_W-1:0] h_wd_d;
  logic              h_wreg_d;
  logic [DATA_W-1:0] h_wdata_d;
  logic [ADDR_W-1:0] h_wd, s_wd;
  logic              h_wreg, s_wreg;
  logic [DATA_W-1:0] h_wdata, s_wdata;

  // Ready is decoded from the state register alone, so MEM back-pressure
  // never reaches EX combinationally.
  assign ex_ready_o  = (state_reg != BUF_FULL);
  assign stallreq_o  = ~ex_ready_o;
  assign mem_valid_o = buf_occupied(state_reg);

  assign push = ex_valid_i & ex_ready_o;
  assign pop  = mem_valid_o & mem_ready_i;

  // Writes to x0 are neutralised at capture time
  assign in_wreg = wreg_i & (wd_i != '0);

  // Occupancy state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= BUF_EMPTY;
    else      state_reg <= state_next;
  end

  // Next state and slot load controls; flush overrides any push/pop
  always_comb begin
    state_next = state_reg;
    h_load     = 1'b0;
    s_load     = 1'b0;
    h_from_s   = 1'b0;
    if (flush_i) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state_reg)
        BUF_EMPTY: begin
          if (push) begin
            h_load     = 1'b1;
            state_next = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            h_load = 1'b1;
          end else if (push) begin
            s_load     = 1'b1;
            state_next = BUF_FULL;
          end else if (pop) begin
            state_next = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            h_load     = 1'b1;
            h_from_s   = 1'b1;
            state_next = BUF_ONE;
          end
        end
        default: state_next = BUF_EMPTY;
      endcase
    end
  end

  // Head refills either from EX or, when draining FULL, from the skid slot
  always_comb begin
    h_wd_d    = wd_i;
    h_wreg_d  = in_wreg;
    h_wdata_d = wdata_i;
    if (h_from_s) begin
      h_wd_d    = s_wd;
      h_wreg_d  = s_wreg;
      h_wdata_d = s_wdata;
    end
  end

  ex_mem_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_head (
    .clk     (clk),
    .rst     (rst),
    .load    (h_load),
    .wd_d    (h_wd_d),
    .wreg_d  (h_wreg_d),
    .wdata_d (h_wdata_d),
    .wd_q    (h_wd),
    .wreg_q  (h_wreg),
    .wdata_q (h_wdata)
  );

  ex_mem_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (s_load),
    .wd_d    (wd_i),
    .wreg_d  (in_wreg),
    .wdata_d (wdata_i),
    .wd_q    (s_wd),
    .wreg_q  (s_wreg),
    .wdata_q (s_wdata)
  );

  // MEM always sees the head slot; it qualifies with mem_valid_o
  assign wd_o    = h_wd;
  assign wreg_o  = h_wreg;
  assign wdata_o = h_wdata;

  // Forward the newest buffered entry: skid when FULL, head when ONE
  always_comb begin
    fwd_we_o    = 1'b0;
    fwd_wd_o    = '0;
    fwd_wdata_o = '0;
    case (state_reg)
      BUF_FULL: begin
        fwd_we_o    = s_wreg;
        fwd_wd_o    = s_wd;
        fwd_wdata_o = s_wdata;
      end
      BUF_ONE: begin
        fwd_we_o    = h_wreg;
        fwd_wd_o    = h_wd;
        fwd_wdata_o = h_wdata;
      end
      default: ;
    endcase
  end

endmodule
